// File: rtl/prm_edge_mask_engine_pkg.sv
// -----------------------------------------------------------------------------
// prm_mask_pkg
// Shared defaults and types for the programmable PRM edge-mask engine.
//   DEF_IN_W  : literals per cube (width of a quantised configuration code)
//   DEF_DEPTH : maximum cubes held in the table
//   DEF_LANES : cubes compared per scan cycle
//   DEF_ID_W  : width of the query tag carried alongside each query
//   cube_t    : one product term, {care mask, literal polarity}
//   state_t   : engine FSM states
// -----------------------------------------------------------------------------
package prm_mask_pkg;

    localparam int DEF_IN_W  = 15;
    localparam int DEF_DEPTH = 512;
    localparam int DEF_LANES = 8;
    localparam int DEF_ID_W  = 16;

    // care bit = 1: the literal takes part in the product.
    // val bit  = 1: literal is X, 0: literal is !X (ignored where care = 0).
    typedef struct packed {
        logic [DEF_IN_W-1:0] care;
        logic [DEF_IN_W-1:0] val;
    } cube_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prm_edge_mask_engine_cube_match.sv
// -----------------------------------------------------------------------------
// prm_cube_match
// LANES parallel cube comparators plus a lowest-index priority encoder.
//   code     : configuration code under test
//   care     : LANES care masks, lane l at [l*IN_W +: IN_W]
//   val      : LANES polarity vectors, same packing as care
//   en       : per-lane enable; a disabled lane never matches
//   any_hit  : at least one enabled lane matches
//   hit_lane : lowest matching lane (0 when any_hit = 0)
// -----------------------------------------------------------------------------
module prm_cube_match #(
    parameter int IN_W  = 15,
    parameter int LANES = 8
) (
    input  logic [IN_W-1:0]          code,
    input  logic [LANES*IN_W-1:0]    care,
    input  logic [LANES*IN_W-1:0]    val,
    input  logic [LANES-1:0]         en,
    output logic                     any_hit,
    output logic [$clog2(LANES)-1:0] hit_lane
);

    localparam int LB = $clog2(LANES);

    logic [LANES-1:0] match;

    always_comb begin
        match = '0;
        for (int l = 0; l < LANES; l++) begin
            match[l] = en[l] &&
                       (((code ^ val[l*IN_W +: IN_W]) & care[l*IN_W +: IN_W]) == '0);
        end
    end

    assign any_hit = |match;

    // Walk from the top lane down so the lowest matching lane is written last.
    always_comb begin
        hit_lane = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (match[l]) begin
                hit_lane = LB'(l);
            end
        end
    end

endmodule

// File: rtl/prm_edge_mask_engine.sv
// -----------------------------------------------------------------------------
// prm_edge_mask_engine
// Evaluates a sum-of-products edge mask over a loadable cube table. One query
// is in flight at a time; the table is scanned LANES cubes per cycle and the
// first matching cube index is reported with the mask.
//
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   cfg_we/addr/care/val    : write one cube (honoured only while idle)
//   cfg_num_we/num/inv      : load active cube count (clamped to DEPTH) and
//                             output inversion flag (honoured only while idle)
//   cfg_err                 : one-cycle pulse after a dropped config write
//   q_valid/q_ready/q_code/q_id          : query channel
//   r_valid/r_ready/r_mask/r_hit/r_hit_idx/r_id : result channel
//   dbg_state               : current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. q_ready is high only in IDLE. Once r_valid rises, r_mask, r_hit,
// r_hit_idx and r_id stay constant until the edge where r_ready is high.
// -----------------------------------------------------------------------------
module prm_edge_mask_engine
    import prm_mask_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LANES = DEF_LANES,
    parameter int ID_W  = DEF_ID_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic [IN_W-1:0]          cfg_care,
    input  logic [IN_W-1:0]          cfg_val,
    input  logic                     cfg_num_we,
    input  logic [$clog2(DEPTH):0]   cfg_num,
    input  logic                     cfg_inv,
    output logic                     cfg_err,
    input  logic                     q_valid,
    output logic                     q_ready,
    input  logic [IN_W-1:0]          q_code,
    input  logic [ID_W-1:0]          q_id,
    output logic                     r_valid,
    input  logic                     r_ready,
    output logic                     r_mask,
    output logic                     r_hit,
    output logic [$clog2(DEPTH)-1:0] r_hit_idx,
    output logic [ID_W-1:0]          r_id,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int LB = $clog2(LANES);
    localparam int GW = AW - LB;

    state_t state_q, state_d;

    logic [GW-1:0]   grp_q;
    logic [IN_W-1:0] code_q;
    logic [NW-1:0]   num_q;
    logic            inv_q;
    logic            cfg_err_q;
    logic            r_valid_q;
    logic            r_hit_q;
    logic            r_mask_q;
    logic [AW-1:0]   r_idx_q;
    logic [ID_W-1:0] r_id_q;

    // Table storage is deliberately not reset; num_q = 0 empties the table.
    logic [IN_W-1:0] care_mem [DEPTH];
    logic [IN_W-1:0] val_mem  [DEPTH];

    logic [LANES*IN_W-1:0] lane_care;
    logic [LANES*IN_W-1:0] lane_val;
    logic [LANES-1:0]      lane_en;
    logic                  any_hit;
    logic [LB-1:0]         hit_lane;
    logic [NW-1:0]         grp_end;
    logic                  last_grp;
    logic                  cfg_open;
    logic                  accept;
    logic                  xfer;

    assign cfg_open = (state_q == ST_IDLE);
    assign accept   = q_valid && cfg_open;
    assign xfer     = r_valid_q && r_ready;

    // Group read: lanes beyond the active count are disabled.
    always_comb begin
        lane_care = '0;
        lane_val  = '0;
        lane_en   = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_care[l*IN_W +: IN_W] = care_mem[{grp_q, LB'(l)}];
            lane_val[l*IN_W +: IN_W]  = val_mem[{grp_q, LB'(l)}];
            lane_en[l]                = ({1'b0, grp_q, LB'(l)} < num_q);
        end
    end

    // The current group is the last one when it reaches or passes num.
    // With num = 0 group 0 is already last, giving exactly one scan cycle.
    assign grp_end  = NW'({grp_q, {LB{1'b0}}}) + NW'(LANES);
    assign last_grp = (grp_end >= num_q);

    prm_cube_match #(
        .IN_W  (IN_W),
        .LANES (LANES)
    ) u_match (
        .code     (code_q),
        .care     (lane_care),
        .val      (lane_val),
        .en       (lane_en),
        .any_hit  (any_hit),
        .hit_lane (hit_lane)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_SCAN;
            ST_SCAN: if (any_hit || last_grp) state_d = ST_DONE;
            ST_DONE: if (xfer) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        q_ready   = (state_q == ST_IDLE);
        r_valid   = r_valid_q;
        cfg_err   = cfg_err_q;
        dbg_state = state_q;
    end

    assign r_hit     = r_hit_q;
    assign r_mask    = r_mask_q;
    assign r_hit_idx = r_idx_q;
    assign r_id      = r_id_q;

    // Cube writes; the scan reads the table from the cycle after accept, so a
    // write landing on the accept edge is already visible to that query.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_open && rst_n) begin
            care_mem[cfg_addr] <= cfg_care;
            val_mem[cfg_addr]  <= cfg_val;
        end
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            num_q     <= '0;
            inv_q     <= 1'b0;
            cfg_err_q <= 1'b0;
            r_valid_q <= 1'b0;
            r_hit_q   <= 1'b0;
            r_mask_q  <= 1'b0;
            r_idx_q   <= '0;
            r_id_q    <= '0;
            grp_q     <= '0;
            code_q    <= '0;
        end else begin
            cfg_err_q <= (cfg_we || cfg_num_we) && !cfg_open;

            if (cfg_num_we && cfg_open) begin
                num_q <= (cfg_num > NW'(DEPTH)) ? NW'(DEPTH) : cfg_num;
                inv_q <= cfg_inv;
            end

            // r_valid rises one cycle after the result is captured and drops
            // on the transfer edge.
            r_valid_q <= (state_q == ST_DONE) && !xfer;

            if (accept) begin
                code_q <= q_code;
                r_id_q <= q_id;
                grp_q  <= '0;
            end else if (state_q == ST_SCAN) begin
                // inv_q cannot change mid-query, so it equals its accept value.
                if (any_hit) begin
                    r_hit_q  <= 1'b1;
                    r_mask_q <= !inv_q;
                    r_idx_q  <= {grp_q, hit_lane};
                end else if (last_grp) begin
                    r_hit_q  <= 1'b0;
                    r_mask_q <= inv_q;
                    r_idx_q  <= '0;
                end else begin
                    grp_q <= grp_q + GW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// -----------------------------------------------------------------------------
// tb_prm_edge_mask_engine
// Stimulus drives cube/num writes and queries; every accepted query pushes its
// expected result (from a linear-search reference model) into exp_q, and a
// monitor on the result channel pops and compares independently.
// -----------------------------------------------------------------------------
module tb_prm_edge_mask_engine;
    import prm_mask_pkg::*;

    localparam int IN_W  = DEF_IN_W;
    localparam int DEPTH = DEF_DEPTH;
    localparam int LANES = DEF_LANES;
    localparam int ID_W  = DEF_ID_W;
    localparam int AW    = $clog2(DEPTH);
    localparam int NW    = AW + 1;
    localparam int EW    = 2 + AW + ID_W + 8;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic            cfg_we     = 1'b0;
    logic [AW-1:0]   cfg_addr   = '0;
    logic [IN_W-1:0] cfg_care   = '0;
    logic [IN_W-1:0] cfg_val    = '0;
    logic            cfg_num_we = 1'b0;
    logic [NW-1:0]   cfg_num    = '0;
    logic            cfg_inv    = 1'b0;
    logic            cfg_err;
    logic            q_valid    = 1'b0;
    logic            q_ready;
    logic [IN_W-1:0] q_code     = '0;
    logic [ID_W-1:0] q_id       = '0;
    logic            r_valid;
    logic            r_ready    = 1'b1;
    logic            r_mask;
    logic            r_hit;
    logic [AW-1:0]   r_hit_idx;
    logic [ID_W-1:0] r_id;
    logic [1:0]      dbg_state;

    prm_edge_mask_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_care   (cfg_care),
        .cfg_val    (cfg_val),
        .cfg_num_we (cfg_num_we),
        .cfg_num    (cfg_num),
        .cfg_inv    (cfg_inv),
        .cfg_err    (cfg_err),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_code     (q_code),
        .q_id       (q_id),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_mask     (r_mask),
        .r_hit      (r_hit),
        .r_hit_idx  (r_hit_idx),
        .r_id       (r_id),
        .dbg_state  (dbg_state)
    );

    // ---------------- reference model state ----------------
    cube_t m_tab [DEPTH];
    int    m_num = 0;
    logic  m_inv = 1'b0;

    // ---------------- scoreboard ----------------
    logic [EW-1:0] exp_q[$];   // {hit, mask, idx, id, latency}
    int            acc_q[$];   // cycle number of the accept edge
    int            n_vec = 0;
    int            n_err = 0;
    bit            head_seen = 1'b0;
    int            rr_mode = 0; // 0: always ready, 1: hold off, 2: random
    int            id_ctr = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First matching cube by linear search; latency from group arithmetic.
    function automatic logic [EW-1:0] model(input logic [IN_W-1:0] code, input logic [ID_W-1:0] id);
        bit hit = 1'b0;
        int idx = 0;
        int lat;
        for (int i = 0; i < m_num; i++) begin
            if (!hit && (((code ^ m_tab[i].val) & m_tab[i].care) == '0)) begin
                hit = 1'b1;
                idx = i;
            end
        end
        if (hit) lat = idx / LANES + 2;
        else if (m_num == 0) lat = 2;
        else lat = (m_num + LANES - 1) / LANES + 1;
        return {hit, hit ^ m_inv, AW'(idx), id, 8'(lat)};
    endfunction

    // ---------------- result monitor ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (rst_n && r_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_r_valid", 32'(r_valid), 32'd0);
            end else begin
                e = exp_q[0];
                if (!head_seen) begin
                    check("latency", 32'(cyc - acc_q[0]), 32'(e[7:0]));
                    head_seen = 1'b1;
                end
                check("r_hit", 32'(r_hit), 32'(e[EW-1]));
                check("r_mask", 32'(r_mask), 32'(e[EW-2]));
                check("r_hit_idx", 32'(r_hit_idx), 32'(e[8+ID_W +: AW]));
                check("r_id", 32'(r_id), 32'(e[8 +: ID_W]));
                check("q_ready_busy", 32'(q_ready), 32'd0);
                if (r_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    head_seen = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       r_ready = 1'b1;
            1:       r_ready = 1'b0;
            default: r_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // ---------------- driver tasks ----------------
    task automatic cfg_write(input int addr, input logic [IN_W-1:0] care, input logic [IN_W-1:0] val);
        cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_care = care; cfg_val = val;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_tab[addr].care = care;
        m_tab[addr].val  = val;
    endtask

    task automatic set_num(input int num, input logic inv);
        cfg_num_we = 1'b1; cfg_num = NW'(num); cfg_inv = inv;
        @(posedge clk); #1;
        cfg_num_we = 1'b0;
        m_num = (num > DEPTH) ? DEPTH : num;
        m_inv = inv;
    endtask

    task automatic do_query(input logic [IN_W-1:0] code, input bit wr, input int wr_addr,
                            input logic [IN_W-1:0] wr_care, input logic [IN_W-1:0] wr_val);
        int n = 0;
        logic [ID_W-1:0] id = ID_W'(id_ctr);
        id_ctr++;
        q_code = code; q_id = id; q_valid = 1'b1;
        if (wr) begin
            cfg_we = 1'b1; cfg_addr = AW'(wr_addr); cfg_care = wr_care; cfg_val = wr_val;
        end
        @(negedge clk);
        while (!q_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!q_ready) begin
            check("q_ready_timeout", 32'd0, 32'd1);
        end else begin
            if (wr) begin
                m_tab[wr_addr].care = wr_care;
                m_tab[wr_addr].val  = wr_val;
            end
            exp_q.push_back(model(code, id));
            acc_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        q_valid = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic query(input logic [IN_W-1:0] code);
        do_query(code, 1'b0, 0, '0, '0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("result_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            acc_q.delete();
            head_seen = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_q_ready"}, 32'(q_ready), 32'd1);
        check({tag, "_r_valid"}, 32'(r_valid), 32'd0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 32'd0);
        check({tag, "_r_hit"}, 32'(r_hit), 32'd0);
        check({tag, "_r_mask"}, 32'(r_mask), 32'd0);
        check({tag, "_r_hit_idx"}, 32'(r_hit_idx), 32'd0);
        check({tag, "_r_id"}, 32'(r_id), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        bit seen;
        logic [1:0] snap;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        // Empty table
        query(15'h1234);
        wait_idle();

        // Single fully-specified cube
        cfg_write(0, 15'h7FFF, 15'h4C3A);
        set_num(1, 1'b0);
        query(15'h4C3A);
        wait_idle();
        query(15'h4C3B);
        wait_idle();

        // Cubes 5 and 9 both match; lowest wins, then inverted
        for (int a = 1; a < 10; a++) begin
            if (a == 5 || a == 9) cfg_write(a, 15'h00F0, 15'h0050);
            else cfg_write(a, 15'h7FFF, 15'h0000);
        end
        set_num(10, 1'b0);
        query(15'h0A50);
        wait_idle();
        set_num(10, 1'b1);
        query(15'h0A50);
        wait_idle();

        // Cube write on the accept edge is seen by that query
        do_query(15'h0123, 1'b1, 2, 15'h7FFF, 15'h0123);
        wait_idle();

        // Backpressure hold with dropped config writes
        rr_mode = 1;
        query(15'h0A50);
        n = 0;
        while (!r_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", 32'(r_valid), 32'd1);
        snap = dbg_state;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            cfg_we = (k == 3); cfg_addr = '0; cfg_care = '0; cfg_val = '0;
            cfg_num_we = (k == 6); cfg_num = '0; cfg_inv = 1'b0;
            @(negedge clk);
            check("bp_state_stable", 32'(dbg_state), 32'(snap));
            check("bp_cfg_err", 32'(cfg_err), 32'((k == 4) || (k == 7)));
        end
        @(posedge clk); #1;
        cfg_we = 1'b0; cfg_num_we = 1'b0;
        rr_mode = 0;
        wait_idle();
        query(15'h0A50);
        wait_idle();

        // Full table, single deep match, count clamped
        for (int a = 0; a < DEPTH; a++) begin
            if (a == 300) cfg_write(a, 15'h0003, 15'h0001);
            else cfg_write(a, 15'h7FFF, 15'h7FFF);
        end
        set_num(700, 1'b0);
        query(15'h0001);
        wait_idle();
        query(15'h0002);
        wait_idle();

        // Reset during a long scan: no result, num cleared, table kept
        q_code = 15'h0002; q_id = 16'hBEEF; q_valid = 1'b1;
        @(posedge clk); #1;
        q_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        m_num = 0;
        m_inv = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        seen = 1'b0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (r_valid) seen = 1'b1;
        end
        check("no_result_after_reset", 32'(seen), 32'd0);
        @(posedge clk); #1;
        query(15'h0001);
        wait_idle();
        set_num(512, 1'b0);
        query(15'h0001);
        wait_idle();

        // Randomised tables, counts, inversion, codes and result backpressure
        rr_mode = 2;
        for (int t = 0; t < 6; t++) begin
            for (int a = 0; a < 64; a++) begin
                cfg_write(a, IN_W'($urandom & $urandom & $urandom), IN_W'($urandom));
            end
            for (int k = 0; k < 8; k++) begin
                set_num($urandom_range(0, 64), 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 1) == 1)
                    query(m_tab[$urandom_range(0, 63)].val ^ IN_W'($urandom & $urandom & $urandom));
                else
                    query(IN_W'($urandom));
                wait_idle();
            end
        end
        rr_mode = 0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected finish before %0d cycles", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
